ysyx_23060061_mem_arbiter: RTL and testbench

Two-master, one-slave memory bus arbiter that sits directly downstream of the IFU and the LSU and upstream of the shared memory port. Each master issues one request and receives one response; the arbiter serialises them onto the single memory interface. Grants are round-robin on contention, and at most one transaction is outstanding. This lets the multi-cycle core share one memory model or SRAM between instruction fetch and data access.

---
 rtl/ysyx_23060061_mem_arbiter_if.sv | 26 ++
 rtl/ysyx_23060061_mem_arbiter.sv | 109 ++++++++++
 tb/tb_ysyx_23060061_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060061_mem_arbiter_if.sv
// Request/response bus shared by the IFU, LSU and memory port of the arbiter.
// The master side issues requests and accepts responses; the slave side answers them.
interface ysyx_23060061_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one memory port, one transaction in flight.
// Grant costs one IDLE cycle; REQ/RESP are zero-latency pass-through, so memory and master stalls propagate directly.
module ysyx_23060061_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  ysyx_23060061_mem_arbiter_if.slave         i_ifu,
  ysyx_23060061_mem_arbiter_if.slave         i_lsu,
  ysyx_23060061_mem_arbiter_if.master        o_mem,
  output logic                               o_busy,
  output logic                               o_grant_lsu
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t r_state;
  logic   r_last;
  logic   r_grant_lsu;
  logic   r_busy;

  logic                w_in_req;
  logic                w_in_resp;
  logic                w_any_req;
  logic                w_pick_lsu;
  logic                w_sel_req_valid;
  logic                w_sel_resp_ready;
  logic                w_req_hs;
  logic                w_resp_hs;
  logic                w_lsu_req;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_lsu_wdata;
  logic [DATA_W/8-1:0] w_lsu_wmask;
  logic                w_unused_ifu_wr;

  assign w_in_req   = (r_state == S_REQ);
  assign w_in_resp  = (r_state == S_RESP);
  assign w_any_req  = i_ifu.req_valid | i_lsu.req_valid;
  // On a tie the master that did not win last time takes the grant.
  assign w_pick_lsu = i_lsu.req_valid & (~i_ifu.req_valid | ~r_last);

  assign w_sel_req_valid  = r_grant_lsu ? i_lsu.req_valid  : i_ifu.req_valid;
  assign w_sel_resp_ready = r_grant_lsu ? i_lsu.resp_ready : i_ifu.resp_ready;
  assign w_sel_addr       = r_grant_lsu ? i_lsu.req_addr   : i_ifu.req_addr;
  assign w_lsu_req        = w_in_req & r_grant_lsu;
  assign w_lsu_wdata      = i_lsu.req_wdata;
  assign w_lsu_wmask      = i_lsu.req_wmask;

  // The IFU only reads; its write fields never reach memory.
  assign w_unused_ifu_wr = ^{i_ifu.req_wen, i_ifu.req_wdata, i_ifu.req_wmask};

  assign o_mem.req_valid  = w_in_req & w_sel_req_valid;
  assign o_mem.req_addr   = w_in_req ? w_sel_addr : '0;
  assign o_mem.req_wen    = w_lsu_req & i_lsu.req_wen;
  assign o_mem.req_wdata  = w_lsu_req ? w_lsu_wdata : '0;
  assign o_mem.req_wmask  = w_lsu_req ? w_lsu_wmask : '0;
  assign o_mem.resp_ready = w_in_resp & w_sel_resp_ready;

  assign i_ifu.req_ready  = w_in_req  & ~r_grant_lsu & o_mem.req_ready;
  assign i_lsu.req_ready  = w_in_req  &  r_grant_lsu & o_mem.req_ready;
  assign i_ifu.resp_valid = w_in_resp & ~r_grant_lsu & o_mem.resp_valid;
  assign i_lsu.resp_valid = w_in_resp &  r_grant_lsu & o_mem.resp_valid;
  assign i_ifu.resp_rdata = (w_in_resp & ~r_grant_lsu) ? o_mem.resp_rdata : '0;
  assign i_lsu.resp_rdata = (w_in_resp &  r_grant_lsu) ? o_mem.resp_rdata : '0;

  assign w_req_hs  = o_mem.req_valid  & o_mem.req_ready;
  assign w_resp_hs = o_mem.resp_valid & o_mem.resp_ready;

  assign o_busy      = r_busy;
  assign o_grant_lsu = r_grant_lsu;

  // last resets to LSU so the first tie after reset goes to the IFU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_grant_lsu <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_lsu <= w_pick_lsu;
            r_last      <= w_pick_lsu;
            r_busy      <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_req_hs) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Directed bench: per-cycle vector table for the basic flows, hand sequences for stalls and async reset.
module tb_ysyx_23060061_mem_arbiter;

  typedef struct packed {
    logic        iv;  logic [31:0] ia;  logic irr;
    logic        lv;  logic [31:0] la;  logic lw;  logic [31:0] ld;  logic [3:0] lm;  logic lrr;
    logic        mrq; logic        mrv; logic [31:0] mrd;
  } in_t;

  typedef struct packed {
    logic        mv;  logic [31:0] ma;  logic mw;  logic [31:0] md;  logic [3:0] mm;  logic mrr;
    logic        iqr; logic        irv; logic [31:0] ird;
    logic        lqr; logic        lrv; logic [31:0] lrd;
    logic        busy; logic       gl;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  localparam logic [31:0] Z    = 32'h0;
  localparam logic [31:0] A    = 32'h8000_0000;
  localparam logic [31:0] LA   = 32'h8000_1000;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;
  localparam logic [31:0] R1   = 32'h0000_0413;
  localparam logic [31:0] R2   = 32'h0010_0093;
  localparam logic [31:0] R3   = 32'h0000_0011;
  localparam logic [31:0] D1   = 32'h1234_5678;
  localparam logic [31:0] D2   = 32'hCAFE_F00D;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  logic busy;
  logic grant_lsu;
  int   total;
  int   bad;
  vec_t vecs[$];

  ysyx_23060061_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_if ();
  ysyx_23060061_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_if ();
  ysyx_23060061_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  ysyx_23060061_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ifu       (ifu_if),
    .i_lsu       (lsu_if),
    .o_mem       (mem_if),
    .o_busy      (busy),
    .o_grant_lsu (grant_lsu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(logic iv, logic [31:0] ia, logic irr,
                                logic lv, logic [31:0] la, logic lw, logic [31:0] ld,
                                logic [3:0] lm, logic lrr,
                                logic mrq, logic mrv, logic [31:0] mrd);
    return '{iv, ia, irr, lv, la, lw, ld, lm, lrr, mrq, mrv, mrd};
  endfunction

  function automatic out_t mk_out(logic mv, logic [31:0] ma, logic mw, logic [31:0] md,
                                  logic [3:0] mm, logic mrr,
                                  logic iqr, logic irv, logic [31:0] ird,
                                  logic lqr, logic lrv, logic [31:0] lrd,
                                  logic b, logic g);
    return '{mv, ma, mw, md, mm, mrr, iqr, irv, ird, lqr, lrv, lrd, b, g};
  endfunction

  function automatic out_t idle_out(logic g);
    return mk_out(0, Z, 0, Z, 0, 0, 0, 0, Z, 0, 0, Z, 0, g);
  endfunction

  task automatic add(input string n, input in_t i, input out_t o);
    vec_t v;
    v.name = n; v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  // IFU write fields are tied to non-zero junk to show they are masked on IFU grants.
  task automatic apply(input in_t v);
    ifu_if.req_valid  = v.iv;
    ifu_if.req_addr   = v.ia;
    ifu_if.req_wen    = 1'b1;
    ifu_if.req_wdata  = JUNK;
    ifu_if.req_wmask  = 4'hF;
    ifu_if.resp_ready = v.irr;
    lsu_if.req_valid  = v.lv;
    lsu_if.req_addr   = v.la;
    lsu_if.req_wen    = v.lw;
    lsu_if.req_wdata  = v.ld;
    lsu_if.req_wmask  = v.lm;
    lsu_if.resp_ready = v.lrr;
    mem_if.req_ready  = v.mrq;
    mem_if.resp_valid = v.mrv;
    mem_if.resp_rdata = v.mrd;
  endtask

  function automatic out_t sample();
    return '{mem_if.req_valid, mem_if.req_addr, mem_if.req_wen, mem_if.req_wdata,
             mem_if.req_wmask, mem_if.resp_ready,
             ifu_if.req_ready, ifu_if.resp_valid, ifu_if.resp_rdata,
             lsu_if.req_ready, lsu_if.resp_valid, lsu_if.resp_rdata,
             busy, grant_lsu};
  endfunction

  task automatic chk_out(input string n, input out_t got, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", n, got, exp);
    end
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", n, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    apply(mk_in(1, A, 1, 1, LA, 1, WD, 4'h3, 1, 1, 1, R1));

    // IFU read
    add("idle_after_rst", mk_in(0, Z, 0, 0, Z, 0, Z, 0, 0, 0, 0, Z), idle_out(0));
    add("ifu_seen_idle",  mk_in(1, A, 1, 0, Z, 0, Z, 0, 0, 1, 0, Z), idle_out(0));
    add("ifu_req",        mk_in(1, A, 1, 0, Z, 0, Z, 0, 0, 1, 0, Z),
        mk_out(1, A, 0, Z, 0, 0, 1, 0, Z, 0, 0, Z, 1, 0));
    add("ifu_resp_wait",  mk_in(0, Z, 1, 0, Z, 0, Z, 0, 0, 1, 0, Z),
        mk_out(0, Z, 0, Z, 0, 1, 0, 0, Z, 0, 0, Z, 1, 0));
    add("ifu_resp",       mk_in(0, Z, 1, 0, Z, 0, Z, 0, 0, 1, 1, R1),
        mk_out(0, Z, 0, Z, 0, 1, 0, 1, R1, 0, 0, Z, 1, 0));
    add("resp_in_idle",   mk_in(0, Z, 1, 0, Z, 0, Z, 0, 1, 1, 1, JUNK), idle_out(0));
    // LSU store
    add("lsu_seen_idle",  mk_in(0, Z, 0, 1, LA, 1, WD, 4'h3, 1, 1, 0, Z), idle_out(0));
    add("lsu_store_req",  mk_in(0, Z, 0, 1, LA, 1, WD, 4'h3, 1, 1, 0, Z),
        mk_out(1, LA, 1, WD, 4'h3, 0, 0, 0, Z, 1, 0, Z, 1, 1));
    add("lsu_store_resp", mk_in(0, Z, 0, 0, Z, 0, Z, 0, 1, 1, 1, D1),
        mk_out(0, Z, 0, Z, 0, 1, 0, 0, Z, 0, 1, D1, 1, 1));
    add("idle_hold_gl",   mk_in(0, Z, 0, 0, Z, 0, Z, 0, 0, 0, 0, Z), idle_out(1));
    // Ties alternate: last winner was LSU, so IFU first
    add("tie1_idle",      mk_in(1, A+4, 1, 1, LA+8, 0, Z, 0, 1, 1, 0, Z), idle_out(1));
    add("tie1_ifu_req",   mk_in(1, A+4, 1, 1, LA+8, 0, Z, 0, 1, 1, 0, Z),
        mk_out(1, A+4, 0, Z, 0, 0, 1, 0, Z, 0, 0, Z, 1, 0));
    add("tie1_ifu_resp",  mk_in(0, Z, 1, 1, LA+8, 0, Z, 0, 1, 1, 1, R2),
        mk_out(0, Z, 0, Z, 0, 1, 0, 1, R2, 0, 0, Z, 1, 0));
    add("loser_idle",     mk_in(0, Z, 1, 1, LA+8, 0, Z, 0, 1, 1, 0, Z), idle_out(0));
    add("loser_lsu_req",  mk_in(0, Z, 1, 1, LA+8, 0, Z, 0, 1, 1, 0, Z),
        mk_out(1, LA+8, 0, Z, 0, 0, 0, 0, Z, 1, 0, Z, 1, 1));
    add("loser_lsu_resp", mk_in(0, Z, 1, 0, Z, 0, Z, 0, 1, 1, 1, D2),
        mk_out(0, Z, 0, Z, 0, 1, 0, 0, Z, 0, 1, D2, 1, 1));
    add("tie3_idle",      mk_in(1, A+8, 1, 1, LA+12, 0, Z, 0, 1, 1, 0, Z), idle_out(1));
    add("tie3_ifu_req",   mk_in(1, A+8, 1, 1, LA+12, 0, Z, 0, 1, 1, 0, Z),
        mk_out(1, A+8, 0, Z, 0, 0, 1, 0, Z, 0, 0, Z, 1, 0));
    add("tie3_ifu_resp",  mk_in(0, Z, 1, 1, LA+12, 0, Z, 0, 1, 1, 1, R3),
        mk_out(0, Z, 0, Z, 0, 1, 0, 1, R3, 0, 0, Z, 1, 0));
    add("tie3_done",      mk_in(0, Z, 0, 0, Z, 0, Z, 0, 0, 0, 0, Z), idle_out(0));

    // Reset state with all inputs active
    @(posedge clk); @(posedge clk); #1;
    chk_out("reset_state", sample(), idle_out(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      if (k != 0) @(negedge clk);
      apply(vecs[k].i);
      #1;
      chk_out(vecs[k].name, sample(), vecs[k].o);
    end

    // LSU load: memory request stall, response delay, then master backpressure
    @(negedge clk);
    apply(mk_in(0, Z, 0, 1, LA, 0, Z, 0, 0, 0, 0, Z));
    #1; chk("stall_idle_busy", busy, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("stall_req_valid", mem_if.req_valid, 1);
      chk("stall_lsu_req_ready", lsu_if.req_ready, 0);
      chk("stall_req_busy", {busy, grant_lsu}, 2'b11);
    end
    mem_if.req_ready = 1'b1;
    #1; chk("stall_lsu_req_ready_hs", lsu_if.req_ready, 1);
    @(negedge clk);
    apply(mk_in(0, Z, 0, 0, Z, 0, Z, 0, 1, 0, 0, Z));
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("delay_resp_valid", lsu_if.resp_valid, 0);
      chk("delay_mem_resp_ready", mem_if.resp_ready, 1);
      chk("delay_busy", busy, 1);
      @(negedge clk);
    end
    apply(mk_in(0, Z, 0, 0, Z, 0, Z, 0, 0, 0, 1, D1));
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_lsu_resp_valid", lsu_if.resp_valid, 1);
      chk("bp_mem_resp_ready", mem_if.resp_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    lsu_if.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", mem_if.resp_ready, 1);
    chk("bp_release_rdata", lsu_if.resp_rdata, D1);
    @(negedge clk);
    apply(mk_in(0, Z, 0, 0, Z, 0, Z, 0, 0, 0, 0, Z));
    #1; chk("bp_back_idle", busy, 0);

    // IFU read interrupted by async reset in RESP; last returns to LSU
    @(negedge clk);
    apply(mk_in(1, A, 1, 0, Z, 0, Z, 0, 0, 1, 0, Z));
    @(negedge clk);
    @(negedge clk);
    apply(mk_in(0, Z, 1, 0, Z, 0, Z, 0, 0, 0, 1, R1));
    #1;
    chk_out("rst_pre_resp", sample(), mk_out(0, Z, 0, Z, 0, 1, 0, 1, R1, 0, 0, Z, 1, 0));
    #1 rst = 1'b1;
    #1;
    chk_out("rst_async_out", sample(), idle_out(0));
    #1 rst = 1'b0;
    @(negedge clk);
    apply(mk_in(1, A+16, 1, 1, LA+16, 0, Z, 0, 1, 1, 0, Z));
    #1; chk_out("rst_tie_idle", sample(), idle_out(0));
    @(negedge clk); #1;
    chk_out("rst_tie_ifu_wins", sample(), mk_out(1, A+16, 0, Z, 0, 0, 1, 0, Z, 0, 0, Z, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
